// File: rtl/mult_32x32_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_32x32_if
// Description : Host-side bundle for the sequential 32x32 multiplier:
//               start request, operands, busy status and product result.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_32x32_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [63:0] product;

  // Host side issues requests and reads back status/result
  modport master (output start, a, b, input busy, product);
  // Multiplier side consumes requests and returns status/result
  modport slave  (input start, a, b, output busy, product);
endinterface : mult_32x32_if
`default_nettype wire

// File: rtl/mult_32x32.sv
`default_nettype none
// ============================================================================
// Module      : mult_32x32
// Description : Unsigned 32x32 -> 64 multiplier using one 16x16 multiplier.
//               Four half-word partial products are accumulated over four
//               cycles while busy is high.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_32x32 (
  input  wire logic   clk,
  input  wire logic   reset,   // asynchronous, active-low
  mult_32x32_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A0B0 = 3'd1,
    S_A0B1 = 3'd2,
    S_A1B0 = 3'd3,
    S_A1B1 = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_a_q;
  logic [31:0] r_b_q;
  logic [63:0] r_product;
  logic        r_busy;

  logic [15:0] w_a_sel;
  logic [15:0] w_b_sel;
  logic [31:0] w_pp;
  logic [63:0] w_pp_shifted;

  // Half-word operand selection and partial-product alignment for the current state
  always_comb begin
    w_a_sel      = r_a_q[15:0];
    w_b_sel      = r_b_q[15:0];
    w_pp_shifted = 64'h0;
    if ((r_state == S_A1B0) || (r_state == S_A1B1)) begin
      w_a_sel = r_a_q[31:16];
    end
    if ((r_state == S_A0B1) || (r_state == S_A1B1)) begin
      w_b_sel = r_b_q[31:16];
    end
    w_pp = {16'h0, w_a_sel} * {16'h0, w_b_sel};
    case (r_state)
      S_A0B0:         w_pp_shifted = {32'h0, w_pp};
      S_A0B1, S_A1B0: w_pp_shifted = {16'h0, w_pp, 16'h0};
      S_A1B1:         w_pp_shifted = {w_pp, 32'h0};
      default:        w_pp_shifted = 64'h0;
    endcase
  end

  // Sequencer: latch operands on start, then accumulate one partial product per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_a_q     <= 32'h0;
      r_b_q     <= 32'h0;
      r_product <= 64'h0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_q     <= bus.a;
            r_b_q     <= bus.b;
            r_product <= 64'h0;
            r_busy    <= 1'b1;
            r_state   <= S_A0B0;
          end
        end
        S_A0B0: begin
          r_product <= r_product + w_pp_shifted;
          r_state   <= S_A0B1;
        end
        S_A0B1: begin
          r_product <= r_product + w_pp_shifted;
          r_state   <= S_A1B0;
        end
        S_A1B0: begin
          r_product <= r_product + w_pp_shifted;
          r_state   <= S_A1B1;
        end
        S_A1B1: begin
          // Final term; sum is bounded by (2^32-1)^2 so the 64-bit add cannot wrap
          r_product <= r_product + w_pp_shifted;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.product = r_product;

endmodule : mult_32x32
`default_nettype wire

// File: tb/tb_mult_32x32.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_32x32
// Description : Directed self-checking bench for mult_32x32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_32x32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mult_32x32_if u_if ();

  mult_32x32 u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Present operands with a one-cycle start; checks the state right after E0
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    u_if.a     = a;
    u_if.b     = b;
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    chk1("busy_after_E0", u_if.busy, 1'b1);
    chk64("product_cleared_E0", u_if.product, 64'h0);
  endtask

  // Runs E1..E4 checking busy stays high for three more edges and then falls
  task automatic finish_op(input string tag, input logic [63:0] exp);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("busy_mid", u_if.busy, 1'b1);
    end
    tick();
    chk1("busy_done", u_if.busy, 1'b0);
    chk64(tag, u_if.product, exp);
    tick();
    chk64({tag, "_hold"}, u_if.product, exp);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    u_if.start = 1'b0;
    u_if.a     = 32'h0;
    u_if.b     = 32'h0;

    // Reset held for 4 cycles, then released with no start
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("rst_busy", u_if.busy, 1'b0);
      chk64("rst_product", u_if.product, 64'h0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("idle_busy", u_if.busy, 1'b0);
      chk64("idle_product", u_if.product, 64'h0);
    end

    // Basic small operands
    start_op(32'd2, 32'd3);
    finish_op("p_2x3", 64'd6);

    // Start clears previous 6
    start_op(32'd123, 32'd456);
    finish_op("p_123x456", 64'd56088);

    // Cross terms
    start_op(32'd10000000, 32'd10000000);
    finish_op("p_1e7sq", 64'h00005AF3107A4000);

    // Maximum operands, with E1 intermediate
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    chk64("p_max_E1", u_if.product, 64'h00000000FFFE0001);
    chk1("busy_max_E1", u_if.busy, 1'b1);
    tick();
    tick();
    tick();
    chk1("busy_max_done", u_if.busy, 1'b0);
    chk64("p_max", u_if.product, 64'hFFFFFFFE00000001);

    // Only the high-high term contributes
    start_op(32'h00010000, 32'hFFFF0000);
    finish_op("p_hihi", 64'h0000FFFF00000000);

    // Start re-pulsed while busy with new operands: ignored
    start_op(32'd5, 32'd7);
    u_if.start = 1'b1;
    u_if.a     = 32'd9;
    u_if.b     = 32'd9;
    tick();
    u_if.start = 1'b0;
    chk1("busy_restart_E1", u_if.busy, 1'b1);
    tick();
    tick();
    chk1("busy_restart_E3", u_if.busy, 1'b1);
    tick();
    chk1("busy_restart_done", u_if.busy, 1'b0);
    chk64("p_restart_ignored", u_if.product, 64'd35);

    // Operands changed during busy do not matter
    start_op(32'd1000, 32'd1000);
    u_if.a = 32'hFFFFFFFF;
    u_if.b = 32'h12345678;
    finish_op("p_opchg", 64'd1000000);

    // Start held across E4 is accepted again at E5
    u_if.a     = 32'd2;
    u_if.b     = 32'd3;
    u_if.start = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    chk1("held_busy_E4", u_if.busy, 1'b0);
    chk64("held_p_E4", u_if.product, 64'd6);
    u_if.a = 32'd4;
    u_if.b = 32'd5;
    tick();
    u_if.start = 1'b0;
    chk1("held_busy_E5", u_if.busy, 1'b1);
    chk64("held_p_E5", u_if.product, 64'h0);
    finish_op("p_held", 64'd20);

    // Reset asserted while in A0B1
    start_op(32'd2, 32'd3);
    tick();
    chk64("abort_p_E1", u_if.product, 64'd6);
    #2;
    reset = 1'b0;
    #1;
    chk1("abort_busy", u_if.busy, 1'b0);
    chk64("abort_product", u_if.product, 64'h0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk1("abort_idle_busy", u_if.busy, 1'b0);
    chk64("abort_idle_product", u_if.product, 64'h0);
    start_op(32'd123, 32'd456);
    finish_op("p_after_abort", 64'd56088);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mult_32x32
`default_nettype wire

// File: doc/mult_32x32.md
# mult_32x32

Sequential unsigned 32×32 → 64-bit multiplier built around a single 16×16 multiplier. A one-cycle `start` pulse launches a four-cycle computation. The 64-bit product accumulates four shifted partial products while `busy` is high. It is a standalone arithmetic block for a host that issues `start`, waits for `busy` to fall, and then reads `product`.

## Interface
- No parameters; all widths are fixed.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low. Asserted when 0, it immediately forces all state to reset values. Release is synchronous to `clk`.
- `start` input 1: request a multiplication; sampled on the rising edge only while idle.
- `a` input 32: unsigned multiplicand; sampled on the start edge.
- `b` input 32: unsigned multiplier; sampled on the start edge.
- `busy` output 1: high while a computation is in progress.
- `product` output 64: unsigned result register.

## Operation
- Internal blocks:
  - FSM with states IDLE, A0B0, A0B1, A1B0, A1B1.
  - 32-bit operand registers `a_q` and `b_q`.
  - One 16×16 → 32 unsigned multiplier fed by half-word muxes (`a_sel`, `b_sel`).
  - Shifter on the partial product with shift amounts 0, 16 or 32.
  - 64-bit accumulator register driving `product`.
- IDLE:
  - `busy` = 0 and `product` holds its last value.
  - If `start` = 1 at a rising edge: latch `a_q`←`a`, `b_q`←`b`, clear `product` to 0, go to A0B0.
- A0B0: `product` += `a_q[15:0]`×`b_q[15:0]`; go to A0B1.
- A0B1: `product` += (`a_q[15:0]`×`b_q[31:16]`) << 16; go to A1B0.
- A1B0: `product` += (`a_q[31:16]`×`b_q[15:0]`) << 16; go to A1B1.
- A1B1: `product` += (`a_q[31:16]`×`b_q[31:16]`) << 32; go to IDLE.
- `busy` is a Moore output, high in A0B0, A0B1, A1B0 and A1B1.
- Arithmetic rules:
  - All arithmetic is unsigned.
  - The accumulator add is 64-bit and never overflows: the final sum is ≤ (2³²−1)².
  - Partial products are zero-extended before shifting.
- `start` while busy is ignored; it does not restart or queue a computation.
- Changes on `a` and `b` after the start edge have no effect on the current computation.
- `product` holds its final value until the next accepted `start`, which clears it.

## Timing
- Reset values: state = IDLE, `busy` = 0, `product` = 0, `a_q` = `b_q` = 0.
- Start accepted at rising edge E0:
  - From E0: `busy` = 1 and `product` = 0.
  - After E1: `product` = lo×lo.
  - After E2 and E3: cumulative partial sums.
  - After E4: `product` = full result and `busy` = 0.
- Latency: 4 cycles from the accepting edge to the final result. `busy` is high for exactly 4 cycles.
- Completion rule: the host treats `product` as final on the first cycle `busy` = 0 after a start. Intermediate values during `busy` are defined as above but are not the result.
- Back-to-back operation: the earliest next `start` is sampled at E5, one cycle after completion. Throughput is one product per 5 cycles.
- A `start` held high across E4 into IDLE is accepted at E5 as a new request.
- Reset asserted mid-operation:
  - Immediately: `busy` = 0, `product` = 0, state = IDLE.
  - The aborted computation produces no result.
  - After release, the block waits for a fresh `start`.

## Test plan
- Reset held low for 4 cycles, then released with no `start` → `busy` = 0 and `product` = 0 throughout.
- `a` = 2, `b` = 3, one-cycle `start` → `busy` high for exactly 4 cycles. `product` = 6 when `busy` falls and stays 6 while idle.
- `a` = 123, `b` = 456 → `product` = 56088. A start edge clears the previous 6 to 0.
- `a` = 10000000, `b` = 10000000 → `product` = 100000000000000 (0x00005AF3107A4000). This exercises the cross terms.
- `a` = `b` = 0xFFFFFFFF → `product` = 0xFFFFFFFE00000001.
  - Check the intermediate value after E1: 0x00000000FFFE0001.
  - Then `a` = 0x00010000, `b` = 0xFFFF0000 → `product` = 0x0000FFFF00000000.
- Robustness:
  - `start` pulsed again while busy → ignored, result unchanged.
  - `a`/`b` changed during busy → result unaffected.
  - `reset` driven low in A0B1 → `busy` = 0 and `product` = 0 immediately, then a normal restart after release.
